fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls instruction fetch for the IFU. Owns the fetch PC and selects the next address: sequential, branch target or jump target.
- Drives a single-outstanding request/grant/response handshake to instruction memory.
- Holds each fetched instruction in a one-entry output buffer until decode accepts it.
- Exports the chosen next-address source on pc_select, using the same encoding as the program-counter mux.

Parameters:
RESET_ADDR, 32'h0000_0000, fetch PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = in reset)
branch_taken  in  1  branch redirect request (resolved in a later stage)
branch_addr  in  32  branch target
jump_taken  in  1  jump redirect request
jump_addr  in  32  jump target
stall  in  1  decode cannot accept an instruction this cycle
imem_req  out  1  instruction-memory request
imem_addr  out  32  request address
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
inst_valid  out  1  inst/inst_addr hold a valid instruction
inst  out  32  fetched instruction
inst_addr  out  32  address of inst
pc_select  out  2  next-address source: 0 = pc+4, 1 = branch, 2 = jump

Behaviour:
- Reset (reset = 0, asynchronous):
  - State = IDLE, fetch_pc = RESET_ADDR, kill = 0.
  - imem_req, imem_addr, inst_valid, inst and inst_addr are all 0.
- States:
  - IDLE: always advances to REQ on the next cycle.
  - REQ: imem_req = 1, imem_addr = fetch_pc (combinational from the fetch_pc register). On imem_gnt: inflight_addr <= fetch_pc, go to WAIT.
  - WAIT: imem_req = 0. On imem_rvalid with kill = 0: inst <= imem_rdata, inst_addr <= inflight_addr, inst_valid <= 1, fetch_pc <= inflight_addr + 4, go to HOLD. On imem_rvalid with kill = 1: discard the data, kill <= 0, go to REQ.
  - HOLD: inst_valid = 1. If stall = 0, inst_valid <= 0 and go to REQ. If stall = 1, stay in HOLD with inst, inst_addr and inst_valid stable.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT, HOLD), with zero-wait memory (gnt in the REQ cycle, rvalid the cycle after).
- Redirect (branch_taken | jump_taken), evaluated every cycle in every non-reset state:
  - Target selection: branch has priority over jump (older instruction). Target = branch_addr if branch_taken, else jump_addr. Target bits [1:0] are forced to 00.
  - fetch_pc <= target, and inst_valid <= 0 next cycle (any held instruction is flushed).
  - In IDLE: only fetch_pc is updated.
  - In REQ without imem_gnt: the request is abandoned and the next cycle re-requests at the target. imem_addr may change before gnt; this is permitted by the memory protocol.
  - In REQ with imem_gnt: go to WAIT with kill <= 1.
  - In WAIT without imem_rvalid: kill <= 1.
  - In WAIT with imem_rvalid: the response is discarded and the next state is REQ.
  - In HOLD: the instruction is dropped regardless of stall; next state is REQ.
  - Redirect overrides the sequential fetch_pc update in the same cycle.
- pc_select (combinational): 1 if branch_taken; 2 if jump_taken & ~branch_taken; otherwise 0. Value 3 is never driven.
- imem_rvalid outside WAIT is ignored. This covers stale responses after reset release.
- Arithmetic: inflight_addr + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Reset asserted mid-operation: all state clears immediately; no instruction is presented after reset release until a fresh fetch completes.

Test Plan:
1. Reset, zero-wait memory, stall = 0, RESET_ADDR = 0:
   - Requests issue at 0x0, 0x4, 0x8.
   - inst_valid pulses with inst_addr 0x0, 0x4, 0x8, spaced 3 cycles apart.
   - pc_select stays 0.
2. stall = 1 for 5 cycles while in HOLD:
   - inst_valid, inst and inst_addr stay stable and no imem_req is issued.
   - On stall release, the next request is at inst_addr + 4.
3. branch_taken (branch_addr = 0x100) in the same cycle as jump_taken (jump_addr = 0x200), during HOLD:
   - pc_select = 1 and the held instruction is flushed.
   - The next request is at 0x100.
4. jump_taken (jump_addr = 0x40) in WAIT, with rvalid 2 cycles later carrying 0xDEADBEEF:
   - The data is discarded and inst_valid stays 0.
   - The next request is at 0x40.
5. fetch at 0xFFFF_FFFC completes:
   - The next request is at 0x0000_0000.
   - A target of 0x0000_0103 is fetched as 0x0000_0100.
6. reset asserted in WAIT, then rvalid arrives after release:
   - All outputs go to 0 asynchronously and the stale rvalid is ignored.
   - Fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid handshake to instruction memory and buffers one instruction for decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        jump_taken,
    input  logic [31:0] jump_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic [1:0]  pc_select
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;

    state_t      state, next_state;
    logic [31:0] fetch_pc;
    logic [31:0] inflight_addr;
    logic        kill;

    logic        redirect;
    logic [31:0] target;

    // Branch outranks jump because it belongs to the older instruction.
    assign redirect  = branch_taken | jump_taken;
    assign target    = branch_taken ? {branch_addr[31:2], 2'b00} : {jump_addr[31:2], 2'b00};
    assign pc_select = branch_taken ? SEL_BRANCH : (jump_taken ? SEL_JUMP : SEL_SEQ);

    assign imem_req  = (state == S_REQ);
    assign imem_addr = (state == S_REQ) ? fetch_pc : 32'h0000_0000;

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: next_state = S_REQ;
            S_REQ: begin
                if (imem_gnt) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) next_state = (kill || redirect) ? S_REQ : S_HOLD;
            end
            S_HOLD: begin
                if (redirect || !stall) next_state = S_REQ;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc      <= RESET_ADDR;
            inflight_addr <= 32'h0000_0000;
            kill          <= 1'b0;
            inst_valid    <= 1'b0;
            inst          <= 32'h0000_0000;
            inst_addr     <= 32'h0000_0000;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem_gnt) begin
                        inflight_addr <= fetch_pc;
                        if (redirect) kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (!kill && !redirect) begin
                            inst       <= imem_rdata;
                            inst_addr  <= inflight_addr;
                            inst_valid <= 1'b1;
                            fetch_pc   <= inflight_addr + 32'd4;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) inst_valid <= 1'b0;
                end
                default: ;
            endcase
            // NOTE: this block comes last on purpose; the final non-blocking
            // assignment wins, so a redirect overrides the sequential update.
            if (redirect) begin
                fetch_pc   <= target;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: drives inputs on the falling edge,
// checks outputs there, and hand-computes every expected value.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        jump_taken;
    logic [31:0] jump_addr;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [1:0]  pc_select;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    fetch_sequencer #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .jump_taken   (jump_taken),
        .jump_addr    (jump_addr),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_addr    (inst_addr),
        .pc_select    (pc_select)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Zero-wait memory: grant in the current REQ cycle, data one cycle later.
    task automatic serve(input logic [31:0] data);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        cyc();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        jump_taken   = 1'b0;
        jump_addr    = 32'h0;
        stall        = 1'b0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({imem_req, inst_valid, pc_select} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got req=%b valid=%b sel=%0d, want 0 0 0", imem_req, inst_valid, pc_select);
        end
        checks++;
        if ({imem_addr, inst, inst_addr} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data: got addr=%h inst=%h inst_addr=%h, want all 0", imem_addr, inst, inst_addr);
        end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_sequential();
        int last = 0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== a || inst_valid !== 1'b0 || pc_select !== 2'd0) begin
                failures++;
                $display("FAIL seq_req%0d: got req=%b addr=%h valid=%b sel=%0d, want 1 %h 0 0",
                         i, imem_req, imem_addr, inst_valid, pc_select, a);
            end
            serve(word_at(a));
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== a || inst !== word_at(a)) begin
                failures++;
                $display("FAIL seq_inst%0d: got valid=%b addr=%h inst=%h, want 1 %h %h",
                         i, inst_valid, inst_addr, inst, a, word_at(a));
            end
            if (i > 0) begin
                checks++;
                if (cycle - last !== 3) begin
                    failures++;
                    $display("FAIL seq_spacing%0d: got %0d cycles, want 3", i, cycle - last);
                end
            end
            last = cycle;
            cyc();
        end
    endtask

    task automatic test_stall();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
            failures++;
            $display("FAIL stall_pre_req: got req=%b addr=%h, want 1 0000000c", imem_req, imem_addr);
        end
        serve(word_at(32'hC));
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'hC || inst !== word_at(32'hC) || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: got valid=%b addr=%h inst=%h req=%b, want 1 0000000c %h 0",
                         i, inst_valid, inst_addr, inst, imem_req, word_at(32'hC));
            end
        end
        stall = 1'b0;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: got req=%b addr=%h valid=%b, want 1 00000010 0", imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_branch_jump_priority();
        serve(word_at(32'h10));
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h10) begin
            failures++;
            $display("FAIL prio_hold: got valid=%b addr=%h, want 1 00000010", inst_valid, inst_addr);
        end
        stall        = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        jump_taken   = 1'b1;
        jump_addr    = 32'h200;
        #1;
        checks++;
        if (pc_select !== 2'd1) begin
            failures++;
            $display("FAIL prio_sel: got %0d, want 1", pc_select);
        end
        cyc();
        branch_taken = 1'b0;
        jump_taken   = 1'b0;
        stall        = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || pc_select !== 2'd0) begin
            failures++;
            $display("FAIL prio_redirect: got valid=%b req=%b addr=%h sel=%0d, want 0 1 00000100 0",
                     inst_valid, imem_req, imem_addr, pc_select);
        end
        @(negedge clk);
    endtask

    task automatic test_jump_in_wait();
        imem_gnt = 1'b1;
        cyc();
        imem_gnt   = 1'b0;
        jump_taken = 1'b1;
        jump_addr  = 32'h40;
        #1;
        checks++;
        if (pc_select !== 2'd2 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL jump_sel: got sel=%0d req=%b, want 2 0", pc_select, imem_req);
        end
        cyc();
        jump_taken = 1'b0;
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst === 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL jump_discard: got valid=%b inst=%h, want 0 and not deadbeef", inst_valid, inst);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            failures++;
            $display("FAIL jump_target: got req=%b addr=%h, want 1 00000040", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap_and_align();
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        cyc();
        branch_taken = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_req: got req=%b addr=%h, want 1 fffffffc", imem_req, imem_addr);
        end
        serve(word_at(32'hFFFF_FFFC));
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'hFFFF_FFFC || inst !== word_at(32'hFFFF_FFFC)) begin
            failures++;
            $display("FAIL wrap_inst: got valid=%b addr=%h inst=%h, want 1 fffffffc %h",
                     inst_valid, inst_addr, inst, word_at(32'hFFFF_FFFC));
        end
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
        // Redirect in the same cycle as the grant: the response must be killed.
        jump_taken = 1'b1;
        jump_addr  = 32'h103;
        imem_gnt   = 1'b1;
        cyc();
        jump_taken  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        cyc();
        imem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL align_target: got valid=%b req=%b addr=%h, want 0 1 00000100", inst_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got req=%b addr=%h valid=%b inst=%h inst_addr=%h, want all 0",
                     imem_req, imem_addr, inst_valid, inst, inst_addr);
        end
        @(negedge clk);
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBADC_0DE5;
        cyc();
        imem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL stale_rvalid: got valid=%b req=%b addr=%h, want 0 1 00000000", inst_valid, imem_req, imem_addr);
        end
        serve(word_at(32'h0));
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst !== word_at(32'h0)) begin
            failures++;
            $display("FAIL restart_inst: got valid=%b addr=%h inst=%h, want 1 00000000 %h",
                     inst_valid, inst_addr, inst, word_at(32'h0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_jump_priority();
        test_jump_in_wait();
        test_wrap_and_align();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
